multicycle_control_fsm: RTL and testbench

- Main control unit of the multicycle RV32 subset core.
- Sits directly upstream of the ALU: it decodes the latched instruction fields and sequences the datapath through per-instruction states.
- Drives ALUControl, operand selects and all write enables every cycle.
- Consumes the ALU Zero flag to resolve beq.

---
 rtl/multicycle_control_fsm_pkg.sv | 42 ++++
 rtl/multicycle_control_fsm_if.sv | 34 +++
 rtl/multicycle_control_fsm_alu_decoder.sv | 23 ++
 rtl/multicycle_control_fsm.sv | 123 ++++++++++++
 tb/tb_multicycle_control_fsm.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and encodings for the multicycle RV32 subset control unit:
// state enum, opcodes, ALUControl codes and datapath select encodings.
package multicycle_control_fsm_pkg;

    localparam int OP_W     = 7;
    localparam int ALUCTL_W = 3;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
    } state_t;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the control FSM (master) and the datapath (slave):
// decoded instruction fields and Zero in, enables and selects out.
interface multicycle_control_fsm_if #(
    parameter int OP_W     = 7,
    parameter int ALUCTL_W = 3
);
    logic [OP_W-1:0]     op;
    logic [2:0]          funct3;
    logic                funct7b5;
    logic                Zero;
    logic                PCWrite;
    logic                AdrSrc;
    logic                MemWrite;
    logic                IRWrite;
    logic                RegWrite;
    logic [1:0]          ResultSrc;
    logic [1:0]          ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          ImmSrc;
    logic [ALUCTL_W-1:0] ALUControl;
    logic                illegal;

    modport master (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
    );

    modport slave (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
    );
endinterface

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU operation decoder: maps (is_rtype, funct3, funct7b5) to ALUControl and
// flags funct3 values outside the supported add/sub/and/or subset.
module alu_decoder
    import multicycle_control_fsm_pkg::*;
(
    input  logic                is_rtype,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    output logic [ALUCTL_W-1:0] alu_ctl,
    output logic                illegal
);
    always_comb begin
        alu_ctl = ALU_ADD;
        illegal = 1'b0;
        case (funct3)
            // funct7b5 only selects sub for R-type; addi ignores it
            3'b000:  alu_ctl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_ctl = ALU_AND;
            3'b110:  alu_ctl = ALU_OR;
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32 subset main control FSM. Optional macro ILLEGAL_TRAP_EN makes
// the ILLEGAL state absorbing with illegal=1; otherwise ILLEGAL is a NOP.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int OP_W     = 7,
    parameter int ALUCTL_W = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_fsm_if.master  bus
);
    state_t              state, nxt;
    logic [OP_W-1:0]     op;
    logic [ALUCTL_W-1:0] dec_ctl;
    logic                dec_ill;

    assign op = bus.op;

    alu_decoder u_dec (
        .is_rtype (op == OP_R),
        .funct3   (bus.funct3),
        .funct7b5 (bus.funct7b5),
        .alu_ctl  (dec_ctl),
        .illegal  (dec_ill)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= nxt;
    end

    // Outputs stay at their all-zero defaults while reset is low so no enable
    // can pulse during an asynchronous abort.
    always_comb begin
        nxt            = S_FETCH;
        bus.PCWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ResultSrc  = RES_ALUOUT;
        bus.ALUSrcA    = SRCA_PC;
        bus.ALUSrcB    = SRCB_RS2;
        bus.ImmSrc     = IMM_I;
        bus.ALUControl = ALU_ADD;
        bus.illegal    = 1'b0;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    bus.IRWrite   = 1'b1;
                    bus.PCWrite   = 1'b1;
                    bus.ALUSrcB   = SRCB_FOUR;
                    bus.ResultSrc = RES_ALURESULT;
                    nxt           = S_DECODE;
                end
                S_DECODE: begin
                    bus.ALUSrcA = SRCA_OLDPC;
                    bus.ALUSrcB = SRCB_IMM;
                    bus.ImmSrc  = IMM_B;
                    case (op)
                        OP_LW, OP_SW: nxt = S_MEMADR;
                        OP_R:         nxt = dec_ill ? S_ILLEGAL : S_EXECUTER;
                        OP_I:         nxt = dec_ill ? S_ILLEGAL : S_EXECUTEI;
                        OP_BEQ:       nxt = S_BEQ;
                        OP_JAL:       nxt = S_JAL;
                        default:      nxt = S_ILLEGAL;
                    endcase
                end
                S_MEMADR: begin
                    bus.ALUSrcA = SRCA_RS1;
                    bus.ALUSrcB = SRCB_IMM;
                    bus.ImmSrc  = (op == OP_LW) ? IMM_I : IMM_S;
                    nxt         = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    bus.AdrSrc = 1'b1;
                    nxt        = S_MEMWB;
                end
                S_MEMWB: begin
                    bus.ResultSrc = RES_DATA;
                    bus.RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    bus.AdrSrc   = 1'b1;
                    bus.MemWrite = 1'b1;
                end
                S_EXECUTER: begin
                    bus.ALUSrcA    = SRCA_RS1;
                    bus.ALUControl = dec_ctl;
                    nxt            = S_ALUWB;
                end
                S_EXECUTEI: begin
                    bus.ALUSrcA    = SRCA_RS1;
                    bus.ALUSrcB    = SRCB_IMM;
                    bus.ALUControl = dec_ctl;
                    nxt            = S_ALUWB;
                end
                S_ALUWB: bus.RegWrite = 1'b1;
                S_BEQ: begin
                    bus.ALUSrcA    = SRCA_RS1;
                    bus.ALUControl = ALU_SUB;
                    bus.PCWrite    = bus.Zero;
                end
                S_JAL: begin
                    bus.ALUSrcA = SRCA_OLDPC;
                    bus.ALUSrcB = SRCB_FOUR;
                    bus.PCWrite = 1'b1;
                    nxt         = S_ALUWB;
                end
                S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
                    bus.illegal = 1'b1;
                    nxt         = S_ILLEGAL;
`else
                    nxt         = S_FETCH;
`endif
                end
                default: nxt = S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: a per-instruction cycle table
// model predicts every output each cycle; directed cases pin literal values.
module tb_multicycle_control_fsm;
    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic       regw;
        logic [1:0] res;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] imm;
        logic [2:0] aluc;
        logic       ill;
    } out_t;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    logic clk = 1'b0;
    logic reset = 1'b0;
    multicycle_control_fsm_if bus();
    out_t got, exp;
    bit   exp_vld = 1'b0;
    int   checks = 0;
    int   errors = 0;

    multicycle_control_fsm dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    assign got = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                  bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
                  bus.ALUControl, bus.illegal};

    function automatic bit is_ill(input logic [6:0] op, input logic [2:0] f3);
        bit ok3 = (f3 == 3'd0) || (f3 == 3'd6) || (f3 == 3'd7);
        if (op == LW || op == SW || op == BQ || op == JL) return 1'b0;
        if (op == RT || op == IT) return !ok3;
        return 1'b1;
    endfunction

    // Cycles from FETCH back to FETCH; 0 means the instruction never returns.
    function automatic int model_len(input logic [6:0] op, input logic [2:0] f3);
        if (is_ill(op, f3)) return TRAP ? 0 : 3;
        if (op == LW) return 5;
        if (op == BQ) return 3;
        return 4;
    endfunction

    function automatic logic [2:0] alu_op(input logic [2:0] f3, input bit sub);
        if (f3 == 3'd0) return sub ? 3'b001 : 3'b000;
        if (f3 == 3'd7) return 3'b010;
        return 3'b011;
    endfunction

    // Expected outputs in cycle k of an instruction (k = 0 is FETCH).
    function automatic out_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic f7, input logic z, input int k);
        out_t o = '0;
        if (k == 0) begin
            o.pcw = 1; o.irw = 1; o.srcb = 2'b10; o.res = 2'b10;
        end else if (k == 1) begin
            o.srca = 2'b01; o.srcb = 2'b01; o.imm = 2'b10;
        end else if (is_ill(op, f3)) begin
            o.ill = TRAP;
        end else if (op == LW) begin
            if (k == 2) begin o.srca = 2'b10; o.srcb = 2'b01; end
            else if (k == 3) o.adr = 1;
            else begin o.res = 2'b01; o.regw = 1; end
        end else if (op == SW) begin
            if (k == 2) begin o.srca = 2'b10; o.srcb = 2'b01; o.imm = 2'b01; end
            else begin o.adr = 1; o.memw = 1; end
        end else if (op == RT) begin
            if (k == 2) begin o.srca = 2'b10; o.aluc = alu_op(f3, f7); end
            else o.regw = 1;
        end else if (op == IT) begin
            if (k == 2) begin o.srca = 2'b10; o.srcb = 2'b01; o.aluc = alu_op(f3, 1'b0); end
            else o.regw = 1;
        end else if (op == BQ) begin
            o.srca = 2'b10; o.aluc = 3'b001; o.pcw = z;
        end else begin
            if (k == 2) begin o.srca = 2'b01; o.srcb = 2'b10; o.pcw = 1; end
            else o.regw = 1;
        end
        return o;
    endfunction

    always @(negedge clk) begin
        if (exp_vld) begin
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, got, exp);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, g, e);
        end
    endtask

    // Asynchronous abort: outputs drop at once, then FETCH right after release.
    task automatic do_reset();
        reset = 1'b0;
        exp = '0;
        #1 lit("rst_enables_low", {got.pcw, got.memw, got.irw, got.regw}, 0);
        lit("rst_all_outputs", got, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        exp = model(LW, 3'd0, 1'b0, 1'b0, 0);
        #1 lit("post_rst_fetch", {got.pcw, got.irw, got.aluc}, 5'b11000);
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input int zsel, input int tag, input int abort_k);
        int n = model_len(op, f3);
        int ab = abort_k;
        int lim;
        if (n == 0 && ab < 0) ab = 12;
        lim = (ab >= 0) ? ab : n;
        bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
        for (int k = 0; k < lim; k++) begin
            bus.Zero = (zsel == 2) ? 1'($urandom) : 1'(zsel);
            exp = model(op, f3, f7, bus.Zero, k);
            exp_vld = 1'b1;
            #1;
            if (tag == 1 && k == 4) lit("lw_writeback", {got.regw, got.res, got.memw}, 4'b1010);
            if (tag == 2 && k == 2) lit("sub_aluctl", got.aluc, 3'b001);
            if (tag == 2 && k == 3) lit("sub_regwrite", got.regw, 1);
            if (tag == 3 && k == 2) lit("beq_taken_pcw", got.pcw, 1);
            if (tag == 4 && k == 2) lit("beq_nottaken_pcw", got.pcw, 0);
            if (tag == 5 && k == 2) lit("ori_ctl_srcb_imm", {got.aluc, got.srcb, got.imm}, 7'b0110100);
`ifdef ILLEGAL_TRAP_EN
            if (tag == 6 && k >= 2)
                lit("trap_held", {got.ill, got.pcw, got.memw, got.irw, got.regw}, 5'b10000);
`else
            if (tag == 6 && k == 2) lit("illegal_nop_flag", {got.ill, got.pcw, got.irw}, 0);
`endif
            @(posedge clk); #1;
        end
        if (ab >= 0) do_reset();
    endtask

    initial begin
        bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
        exp = '0;
        exp_vld = 1'b1;
        #2 lit("reset_state", got, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        exp = model(LW, 3'd0, 1'b0, 1'b0, 0);
        #1 lit("first_fetch", {got.pcw, got.irw, got.aluc}, 5'b11000);

        run_instr(LW, 3'd2, 1'b0, 2, 0, 3);      // aborted in MEMREAD
        run_instr(LW, 3'd2, 1'b0, 2, 1, -1);
        run_instr(RT, 3'd0, 1'b1, 2, 2, -1);
        run_instr(BQ, 3'd0, 1'b0, 1, 3, -1);
        run_instr(BQ, 3'd0, 1'b0, 0, 4, -1);
        run_instr(IT, 3'd6, 1'b1, 2, 5, -1);
        run_instr(SW, 3'd2, 1'b0, 2, 0, -1);
        run_instr(JL, 3'd0, 1'b0, 2, 0, -1);
        run_instr(7'h7f, 3'd0, 1'b0, 2, 6, -1);

        for (int i = 0; i < 150; i++) begin
            logic [6:0] op;
            logic [2:0] f3;
            case ($urandom_range(0, 7))
                0: op = LW;
                1: op = SW;
                2: op = RT;
                3: op = IT;
                4: op = BQ;
                5: op = JL;
                6: op = 7'($urandom_range(0, 127));
                default: op = 7'h7f;
            endcase
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 2))
                    0: f3 = 3'd0;
                    1: f3 = 3'd6;
                    default: f3 = 3'd7;
                endcase
            end else f3 = 3'($urandom);
            run_instr(op, f3, 1'($urandom), 2, 0, -1);
        end

        exp_vld = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
